// File: rtl/tone_decoder_pkg.sv
// Shared definitions for the tone decoder: note divider table, FSM state type and the
// interval-to-note matcher used by the decoder.
package tone_decoder_pkg;

    localparam int CNT_W     = 18;
    localparam int NUM_NOTES = 14;

    localparam logic [3:0] NOTE_REST = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } dec_state_e;

    // Generator divider values P for L_1..L_7, M_1..M_7; the square wave toggles every P+1 clk cycles.
    localparam logic [CNT_W-1:0] NOTE_DIV [NUM_NOTES] = '{
        18'd127552, 18'd113635, 18'd101238, 18'd95554, 18'd85136, 18'd75842, 18'd67568,
        18'd63776,  18'd56817,  18'd50619,  18'd47777, 18'd42553, 18'd37920, 18'd33784
    };

    // Returns the 1-based note whose half-period lies within tol of d, or NOTE_REST.
    // Table spacing exceeds 2*tol, so at most one entry can hit.
    function automatic logic [3:0] note_match(input logic [CNT_W-1:0] d, input int tol);
        int diff;
        note_match = NOTE_REST;
        for (int k = 0; k < NUM_NOTES; k++) begin
            diff = int'(d) - int'(NOTE_DIV[k]) - 1;
            if (diff <= tol && diff >= -tol) begin
                note_match = 4'(k + 1);
            end
        end
    endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronizes the asynchronous tone input, flags every transition and measures the
// edge-to-edge interval with a counter that saturates at the silence threshold.
module tone_period_meter
    import tone_decoder_pkg::*;
#(
    parameter int SILENCE_CYC = 200000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tone_i,
    output logic             edge_o,
    output logic [CNT_W-1:0] interval_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(SILENCE_CYC);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= tone_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign edge_o = sync2_q ^ prev_q;

    // Cleared to 1 so the value seen at the next edge equals the cycle count between edges.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_o) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign interval_o = cnt_q;
    assign timeout_o  = (cnt_q == SAT) && !edge_o;

endmodule

// File: rtl/tone_decoder.sv
// Identifies which scale note is playing on tone_in by matching measured half-periods
// against the divider table and locking after a run of identical matches.
module tone_decoder
    import tone_decoder_pkg::*;
#(
    parameter int TOL         = 512,
    parameter int STABLE_CNT  = 3,
    parameter int SILENCE_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic [3:0]  note_idx,
    output logic        note_valid,
    output logic        note_strobe,
    output logic [17:0] half_period,
    output logic [1:0]  state_dbg
);

    localparam logic [3:0] LOCK_CNT = 4'(STABLE_CNT);

    logic             edge_s;
    logic             timeout_s;
    logic [CNT_W-1:0] interval_s;
    logic [3:0]       match_idx;
    logic [3:0]       hit_cnt;

    dec_state_e       state_q;
    logic [3:0]       cand_q;
    logic [3:0]       match_cnt_q;
    logic [3:0]       note_idx_q;
    logic             note_valid_q;
    logic             note_strobe_q;
    logic [CNT_W-1:0] half_period_q;

    tone_period_meter #(
        .SILENCE_CYC (SILENCE_CYC)
    ) u_meter (
        .clk        (clk),
        .rst_n      (rst_n),
        .tone_i     (tone_in),
        .edge_o     (edge_s),
        .interval_o (interval_s),
        .timeout_o  (timeout_s)
    );

    assign match_idx = note_match(interval_s, TOL);

    always_comb begin
        hit_cnt = 4'd1;
        if (match_idx == cand_q) begin
            hit_cnt = match_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cand_q        <= NOTE_REST;
            match_cnt_q   <= '0;
            note_idx_q    <= NOTE_REST;
            note_valid_q  <= 1'b0;
            note_strobe_q <= 1'b0;
            half_period_q <= '0;
        end else begin
            note_strobe_q <= 1'b0;
            case (state_q)
                // The first edge only opens an interval; nothing has been measured yet.
                ST_IDLE: begin
                    if (edge_s) begin
                        state_q     <= ST_ACQUIRE;
                        cand_q      <= NOTE_REST;
                        match_cnt_q <= '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (edge_s) begin
                        half_period_q <= interval_s;
                        if (match_idx == NOTE_REST) begin
                            cand_q      <= NOTE_REST;
                            match_cnt_q <= '0;
                        end else begin
                            cand_q      <= match_idx;
                            match_cnt_q <= hit_cnt;
                            if (hit_cnt >= LOCK_CNT) begin
                                state_q       <= ST_LOCKED;
                                note_idx_q    <= match_idx;
                                note_valid_q  <= 1'b1;
                                note_strobe_q <= 1'b1;
                            end
                        end
                    end else if (timeout_s) begin
                        state_q     <= ST_IDLE;
                        cand_q      <= NOTE_REST;
                        match_cnt_q <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (edge_s) begin
                        half_period_q <= interval_s;
                        if (match_idx != note_idx_q) begin
                            state_q      <= ST_ACQUIRE;
                            note_idx_q   <= NOTE_REST;
                            note_valid_q <= 1'b0;
                            cand_q       <= match_idx;
                            match_cnt_q  <= (match_idx == NOTE_REST) ? 4'd0 : 4'd1;
                        end
                    end else if (timeout_s) begin
                        state_q      <= ST_IDLE;
                        note_idx_q   <= NOTE_REST;
                        note_valid_q <= 1'b0;
                        cand_q       <= NOTE_REST;
                        match_cnt_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign note_idx    = note_idx_q;
    assign note_valid  = note_valid_q;
    assign note_strobe = note_strobe_q;
    assign half_period = half_period_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder: square-wave stimulus against a run-length note model.
module tb_tone_decoder;
    import tone_decoder_pkg::*;

    localparam int TOL     = 512;
    localparam int STABLE  = 3;
    localparam int SILENCE = 200000;

    logic        clk;
    logic        rst_n;
    logic        tone_in;
    logic [3:0]  note_idx;
    logic        note_valid;
    logic        note_strobe;
    logic [17:0] half_period;
    logic [1:0]  state_dbg;

    int checks;
    int errors;
    int dut_strobes;
    int valid_cycles;

    // Expected half-periods (clk cycles) of L_1..L_7, M_1..M_7.
    int ref_half [14] = '{127553, 113636, 101239, 95555, 85137, 75843, 67569,
                          63777, 56818, 50620, 47778, 42554, 37921, 33785};

    // Model: run of consecutive intervals matching the same note.
    bit m_idle;
    int m_run_note;
    int m_run_len;
    int m_strobes;
    int m_half;
    int gap;

    tone_decoder #(
        .TOL         (TOL),
        .STABLE_CNT  (STABLE),
        .SILENCE_CYC (SILENCE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tone_in     (tone_in),
        .note_idx    (note_idx),
        .note_valid  (note_valid),
        .note_strobe (note_strobe),
        .half_period (half_period),
        .state_dbg   (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (note_strobe === 1'b1) dut_strobes++;
        if (note_valid === 1'b1) valid_cycles++;
    end

    function automatic int ref_note(int d);
        for (int k = 0; k < 14; k++) begin
            if (d - ref_half[k] <= TOL && ref_half[k] - d <= TOL) return k + 1;
        end
        return 0;
    endfunction

    function automatic void model_clear();
        m_run_note = 0;
        m_run_len  = 0;
    endfunction

    function automatic void model_timeout();
        if (!m_idle && gap > SILENCE) begin
            m_idle = 1'b1;
            model_clear();
        end
    endfunction

    function automatic void model_edge();
        int n;
        model_timeout();
        if (m_idle) begin
            m_idle = 1'b0;
            model_clear();
        end else begin
            n = ref_note(gap);
            m_half = gap;
            if (n == 0) begin
                model_clear();
            end else if (n == m_run_note) begin
                m_run_len++;
            end else begin
                m_run_note = n;
                m_run_len  = 1;
            end
            if (n != 0 && m_run_len == STABLE) m_strobes++;
        end
        gap = 0;
    endfunction

    function automatic int exp_valid();
        return (m_run_note != 0 && m_run_len >= STABLE) ? 1 : 0;
    endfunction

    function automatic int exp_idx();
        return (exp_valid() != 0) ? m_run_note : 0;
    endfunction

    function automatic int exp_state();
        if (m_idle) return int'(ST_IDLE);
        return (exp_valid() != 0) ? int'(ST_LOCKED) : int'(ST_ACQUIRE);
    endfunction

    task automatic toggle_wait(input int half);
        tone_in = ~tone_in;
        model_edge();
        repeat (half) @(negedge clk);
        gap += half;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
        gap += n;
        model_timeout();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        tone_in = 1'b0;
        repeat (10) @(negedge clk);
        rst_n  = 1'b1;
        m_idle = 1'b1;
        model_clear();
        m_half = 0;
        gap    = 0;
        hold(5);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        tone_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (3) @(negedge clk);
            tone_in = ~tone_in;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (note_idx !== 4'd0 || note_valid !== 1'b0 || note_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_notes: idx=%0d valid=%0b strobe=%0b required 0/0/0", note_idx, note_valid, note_strobe);
        end
        checks++;
        if (half_period !== 18'd0) begin
            errors++;
            $display("FAIL reset_half: got %0d required 0", half_period);
        end
        rst_n  = 1'b1;
        m_idle = 1'b1;
        model_clear();
        m_half = 0;
        gap    = 0;
        hold(SILENCE);
        checks++;
        if (state_dbg !== 2'(exp_state()) || state_dbg !== 2'(ST_IDLE)) begin
            errors++;
            $display("FAIL static_idle: state=%0d required %0d", state_dbg, exp_state());
        end
        checks++;
        if (note_valid !== 1'b0 || dut_strobes != 0 || valid_cycles != 0) begin
            errors++;
            $display("FAIL static_quiet: valid=%0b strobes=%0d valid_cycles=%0d required 0/0/0", note_valid, dut_strobes, valid_cycles);
        end
    endtask

    task automatic test_lock_m1();
        int s0;
        s0 = dut_strobes;
        for (int i = 0; i < 3; i++) toggle_wait(63777);
        checks++;
        if (note_valid !== 1'(exp_valid()) || note_valid !== 1'b0) begin
            errors++;
            $display("FAIL m1_early: valid=%0b required 0", note_valid);
        end
        for (int i = 0; i < 2; i++) toggle_wait(63777);
        checks++;
        if (note_idx !== 4'd8 || note_idx !== 4'(exp_idx()) || note_valid !== 1'b1) begin
            errors++;
            $display("FAIL m1_lock: idx=%0d valid=%0b required 8/1", note_idx, note_valid);
        end
        checks++;
        if (half_period !== 18'd63777) begin
            errors++;
            $display("FAIL m1_half: got %0d required 63777", half_period);
        end
        checks++;
        if (dut_strobes - s0 != 1 || dut_strobes != m_strobes) begin
            errors++;
            $display("FAIL m1_strobe: got %0d strobes required 1 (total %0d vs %0d)", dut_strobes - s0, dut_strobes, m_strobes);
        end
    endtask

    task automatic test_out_of_tol();
        int v0;
        do_reset();
        v0 = valid_cycles;
        for (int i = 0; i < 5; i++) toggle_wait(64377);
        checks++;
        if (valid_cycles != v0 || note_idx !== 4'(exp_idx()) || note_idx !== 4'd0) begin
            errors++;
            $display("FAIL oot_nolock: valid_cycles=%0d idx=%0d required 0/0", valid_cycles - v0, note_idx);
        end
        checks++;
        if (half_period !== 18'(m_half)) begin
            errors++;
            $display("FAIL oot_half: got %0d required %0d", half_period, m_half);
        end
    endtask

    task automatic test_switch();
        int s0;
        do_reset();
        for (int i = 0; i < 4; i++) toggle_wait(63777);
        checks++;
        if (note_idx !== 4'(exp_idx()) || note_valid !== 1'b1) begin
            errors++;
            $display("FAIL sw_m1: idx=%0d valid=%0b required %0d/1", note_idx, note_valid, exp_idx());
        end
        s0 = dut_strobes;
        for (int i = 0; i < 2; i++) toggle_wait(42554);
        checks++;
        if (note_valid !== 1'b0 || note_idx !== 4'(exp_idx())) begin
            errors++;
            $display("FAIL sw_drop: idx=%0d valid=%0b required %0d/0", note_idx, note_valid, exp_idx());
        end
        toggle_wait(42554);
        checks++;
        if (note_valid !== 1'(exp_valid())) begin
            errors++;
            $display("FAIL sw_mid: valid=%0b required %0d", note_valid, exp_valid());
        end
        toggle_wait(42554);
        checks++;
        if (note_idx !== 4'd12 || note_idx !== 4'(exp_idx()) || note_valid !== 1'b1 || dut_strobes - s0 != 1) begin
            errors++;
            $display("FAIL sw_relock: idx=%0d valid=%0b strobes=%0d required 12/1/1", note_idx, note_valid, dut_strobes - s0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) toggle_wait(85137);
        checks++;
        if (note_idx !== 4'd5 || note_valid !== 1'(exp_valid())) begin
            errors++;
            $display("FAIL to_lock: idx=%0d valid=%0b required 5/1", note_idx, note_valid);
        end
        hold(SILENCE);
        checks++;
        if (note_valid !== 1'b0 || note_idx !== 4'd0 || state_dbg !== 2'(exp_state())) begin
            errors++;
            $display("FAIL to_idle: idx=%0d valid=%0b state=%0d required 0/0/%0d", note_idx, note_valid, state_dbg, exp_state());
        end
        checks++;
        if (half_period !== 18'd85137) begin
            errors++;
            $display("FAIL to_half: got %0d required 85137", half_period);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        do_reset();
        for (int i = 0; i < 4; i++) toggle_wait(50620);
        checks++;
        if (note_idx !== 4'd10 || note_valid !== 1'b1) begin
            errors++;
            $display("FAIL rm_lock: idx=%0d valid=%0b required 10/1", note_idx, note_valid);
        end
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (note_idx !== 4'd0 || note_valid !== 1'b0 || half_period !== 18'd0 || state_dbg !== 2'(ST_IDLE)) begin
            errors++;
            $display("FAIL rm_cleared: idx=%0d valid=%0b half=%0d state=%0d required all 0", note_idx, note_valid, half_period, state_dbg);
        end
        rst_n  = 1'b1;
        m_idle = 1'b1;
        model_clear();
        m_half = 0;
        gap    = 0;
        s0 = dut_strobes;
        hold(20);
        for (int i = 0; i < 3; i++) toggle_wait(50620);
        checks++;
        if (note_valid !== 1'b0 || dut_strobes != s0) begin
            errors++;
            $display("FAIL rm_partial: valid=%0b strobes=%0d required 0/0", note_valid, dut_strobes - s0);
        end
        toggle_wait(50620);
        checks++;
        if (note_idx !== 4'(exp_idx()) || note_valid !== 1'b1 || dut_strobes - s0 != 1) begin
            errors++;
            $display("FAIL rm_relock: idx=%0d valid=%0b strobes=%0d required %0d/1/1", note_idx, note_valid, dut_strobes - s0, exp_idx());
        end
    endtask

    task automatic test_boundary();
        do_reset();
        for (int i = 0; i < 4; i++) toggle_wait(33785 + TOL);
        checks++;
        if (note_idx !== 4'd14 || note_valid !== 1'(exp_valid())) begin
            errors++;
            $display("FAIL bd_plus: idx=%0d valid=%0b required 14/1", note_idx, note_valid);
        end
        for (int i = 0; i < 2; i++) toggle_wait(33785 - TOL - 1);
        checks++;
        if (note_valid !== 1'b0 || note_idx !== 4'(exp_idx()) || half_period !== 18'(33785 - TOL - 1)) begin
            errors++;
            $display("FAIL bd_outside: idx=%0d valid=%0b half=%0d required 0/0/%0d", note_idx, note_valid, half_period, 33785 - TOL - 1);
        end
        for (int i = 0; i < 4; i++) toggle_wait(33785 - TOL);
        checks++;
        if (note_idx !== 4'd14 || note_valid !== 1'(exp_valid()) || dut_strobes != m_strobes) begin
            errors++;
            $display("FAIL bd_minus: idx=%0d valid=%0b strobes=%0d required 14/1/%0d", note_idx, note_valid, dut_strobes, m_strobes);
        end
    endtask

    task automatic test_random();
        int n;
        int off;
        int len;
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            n   = int'($urandom_range(0, 13));
            off = int'($urandom_range(0, 1400)) - 700;
            len = int'($urandom_range(2, 4));
            for (int i = 0; i < len; i++) toggle_wait(ref_half[n] + off);
            checks++;
            if (note_idx !== 4'(exp_idx()) || note_valid !== 1'(exp_valid()) || dut_strobes != m_strobes) begin
                errors++;
                $display("FAIL rnd_note seg%0d: idx=%0d valid=%0b strobes=%0d required %0d/%0d/%0d",
                         seg, note_idx, note_valid, dut_strobes, exp_idx(), exp_valid(), m_strobes);
            end
            checks++;
            if (half_period !== 18'(m_half)) begin
                errors++;
                $display("FAIL rnd_half seg%0d: got %0d required %0d", seg, half_period, m_half);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        dut_strobes  = 0;
        valid_cycles = 0;
        m_idle       = 1'b1;
        m_run_note   = 0;
        m_run_len    = 0;
        m_strobes    = 0;
        m_half       = 0;
        gap          = 0;
        rst_n        = 1'b0;
        tone_in      = 1'b0;
        test_reset();
        test_lock_m1();
        test_out_of_tol();
        test_switch();
        test_timeout();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
